// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Word-organised data memory with a valid/ready request channel and a
// valid/ready response channel. Each accepted request is held for a fixed
// number of wait states, then performed against the storage array. The result
// is registered and held until the initiator takes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words
//   WAIT_CYCLES  wait states between request accept and memory access (0..15)
//
// Ports
//   clk        in   single clock, rising edge
//   n_rst      in   synchronous reset, active high (despite the name)
//   req_valid  in   request present
//   req_ready  out  block idle and able to accept a request
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address; word index is addr[31:2]
//   req_wdata  in   write data
//   req_be     in   byte enables, bit i selects wdata[8i+7:8i]
//   rsp_valid  out  response held
//   rsp_ready  in   initiator accepts the response
//   rsp_rdata  out  read data (0 for writes and errors)
//   rsp_err    out  misaligned or out-of-range access
// -----------------------------------------------------------------------------
module dmem_resp #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_32  = 32'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          do_access_s;
   logic          acc_we_s;
   logic [31:0]   acc_addr_s;
   logic [31:0]   acc_wdata_s;
   logic [3:0]    acc_be_s;
   logic          acc_err_s;
   logic [AW-1:0] acc_idx_s;
   logic [31:0]   rd_word_s;
   logic          mem_we_s;

   // Misaligned or beyond the last storage word.
   function automatic logic addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= DEPTH_32);
   endfunction

   // Access operands: with zero wait states the access happens on the accept
   // edge, so it must use the live request rather than the latched copy.
   always_comb begin
      if (state_q == ST_IDLE) begin
         acc_we_s    = req_we;
         acc_addr_s  = req_addr;
         acc_wdata_s = req_wdata;
         acc_be_s    = req_be;
      end else begin
         acc_we_s    = we_q;
         acc_addr_s  = addr_q;
         acc_wdata_s = wdata_q;
         acc_be_s    = be_q;
      end
   end

   assign acc_err_s = addr_err(acc_addr_s);
   assign acc_idx_s = acc_addr_s[AW+1:2];
   assign rd_word_s = mem_q[acc_idx_s];
   // A reset on the access edge wins: the aborted write must not land.
   assign mem_we_s  = do_access_s & acc_we_s & ~acc_err_s & ~n_rst;

   // Next-state, request capture and response generation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      do_access_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = WAIT_INIT;
               if (ZERO_WAIT) begin
                  do_access_s = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               do_access_s = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cnt_d       = 4'd0;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
         end
      endcase

      if (do_access_s) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = acc_err_s;
         rsp_rdata_d = (acc_err_s || acc_we_s) ? 32'd0 : rd_word_s;
      end else begin
         rsp_valid_d = rsp_valid_d;
      end
   end

   // Control and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage array: byte-masked write, contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be_s[b]) begin
               mem_q[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
            end
         end
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
// Two instances: unit 0 with WAIT_CYCLES=2, unit 1 with WAIT_CYCLES=0, both
// DEPTH_WORDS=256. A word-array reference model predicts every response.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        n_rst     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int          wc [2] = '{2, 0};
   logic [31:0] model [2][DEPTH];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .n_rst(n_rst[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .n_rst(n_rst[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One complete transaction with optional response backpressure.
   task automatic txn(input int u, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input int bp);
      int          k;
      logic        exp_e;
      logic [31:0] exp_d;
      logic [31:0] merged;
      logic [31:0] hold_d;
      logic        hold_e;
      exp_e  = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
      exp_d  = 32'd0;
      merged = 32'd0;
      if (!exp_e) begin
         merged = model[u][addr >> 2];
         for (int b = 0; b < 4; b++)
            if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
         if (!we) exp_d = model[u][addr >> 2];
      end

      @(negedge clk);
      req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr;
      req_wdata[u] = wd;   req_be[u] = be;
      k = 0;
      while (!req_ready[u] && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_eq("ready_before_accept", {31'd0, req_ready[u]}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      // Scramble the request after accept: the latched copy must be used.
      req_valid[u] = 1'b0; req_we[u] = ~we; req_addr[u] = $urandom;
      req_wdata[u] = $urandom; req_be[u] = 4'($urandom);
      k = 1;
      while (!rsp_valid[u] && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_eq($sformatf("latency_u%0d", u), k, wc[u] + 1);
      check_eq($sformatf("err_u%0d_a%08h", u, addr), {31'd0, rsp_err[u]}, {31'd0, exp_e});
      check_eq($sformatf("rdata_u%0d_a%08h", u, addr), rsp_rdata[u], exp_d);
      hold_d = rsp_rdata[u];
      hold_e = rsp_err[u];

      if (bp > 0) req_valid[u] = 1'b1;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check_eq("bp_valid", {31'd0, rsp_valid[u]}, 32'd1);
         check_eq("bp_rdata", rsp_rdata[u], hold_d);
         check_eq("bp_err", {31'd0, rsp_err[u]}, {31'd0, hold_e});
         check_eq("bp_no_accept", {31'd0, req_ready[u]}, 32'd0);
      end
      rsp_ready[u] = 1'b1;
      @(negedge clk);
      req_valid[u] = 1'b0;
      rsp_ready[u] = 1'b0;
      check_eq("post_hs_valid", {31'd0, rsp_valid[u]}, 32'd0);
      check_eq("post_hs_ready", {31'd0, req_ready[u]}, 32'd1);

      if (we && !exp_e) model[u][addr >> 2] = merged;
   endtask

   // Mostly legal addresses, with some misaligned and out-of-range ones.
   function automatic logic [31:0] rand_addr();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) return {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      if (sel == 1) return 32'h400 + {$urandom_range(0, 4095), 2'b00};
      return {22'd0, 8'($urandom), 2'b00};
   endfunction

   initial begin
      int rdy_cnt;
      logic [31:0] old20;
      for (int u = 0; u < 2; u++) begin
         n_rst[u] = 1'b1; req_valid[u] = 1'b0; req_we[u] = 1'b0;
         req_addr[u] = 32'd0; req_wdata[u] = 32'd0; req_be[u] = 4'd0;
         rsp_ready[u] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst[0] = 1'b0; n_rst[1] = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check_eq("rst_ready", {31'd0, req_ready[u]}, 32'd1);
         check_eq("rst_valid", {31'd0, rsp_valid[u]}, 32'd0);
         check_eq("rst_rdata", rsp_rdata[u], 32'd0);
         check_eq("rst_err", {31'd0, rsp_err[u]}, 32'd0);
      end

      // Fill every word so the model knows all contents.
      for (int u = 0; u < 2; u++)
         for (int w = 0; w < DEPTH; w++)
            txn(u, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

      // Directed: write/read, byte merge, errors, backpressure.
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      txn(0, 1'b1, 32'h10, 32'h11223344, 4'h5, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'hA, 5);
      check_eq("merge_model", model[0][4], 32'hDE22BE44);
      txn(0, 1'b0, 32'h13, 32'h0, 4'hF, 0);
      txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 2);
      txn(0, 1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
      txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0);
      txn(0, 1'b1, 32'h24, 32'h55AA55AA, 4'h0, 0);
      txn(0, 1'b0, 32'h24, 32'h0, 4'h0, 0);
      txn(0, 1'b0, 32'h3FC, 32'h0, 4'hF, 0);

      // Reset during WAIT aborts the pending write to 0x20.
      old20 = model[0][8];
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
      req_wdata[0] = ~old20; req_be[0] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      n_rst[0] = 1'b1;
      @(negedge clk);
      n_rst[0] = 1'b0;
      check_eq("midrst_ready", {31'd0, req_ready[0]}, 32'd1);
      check_eq("midrst_valid", {31'd0, rsp_valid[0]}, 32'd0);
      @(negedge clk);
      check_eq("midrst_idle", {31'd0, req_ready[0]}, 32'd1);
      check_eq("midrst_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
      txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);

      // Zero-wait back-to-back reads with rsp_ready tied high.
      @(negedge clk);
      rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_we[1] = 1'b0;
      req_addr[1] = 32'h40; req_be[1] = 4'hF;
      rdy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         check_eq("b2b_ready", {31'd0, req_ready[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check_eq("b2b_valid", {31'd0, rsp_valid[1]}, (i % 2 == 0) ? 32'd0 : 32'd1);
         if (rsp_valid[1]) check_eq("b2b_rdata", rsp_rdata[1], model[1][16]);
         if (req_ready[1]) rdy_cnt++;
         @(negedge clk);
      end
      req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
      check_eq("b2b_accepts", rdy_cnt, 32'd10);
      @(negedge clk);

      // Randomized traffic on both units.
      for (int n = 0; n < 150; n++)
         txn(0, 1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3));
      for (int n = 0; n < 80; n++)
         txn(1, 1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
